// File: rtl/regfile_dump_seq.sv
// ---------------------------------------------------------------------------
// regfile_dump_seq
//
// Sequential read-out engine for the MIPS register file. A start pulse makes
// the block request a pipeline freeze; once the freeze is granted it drives
// the two asynchronous register-file read ports over the register range
// FIRST_REG..LAST_REG, two registers per read, and streams every register
// value out over a valid/ready interface. The block owns the read-port
// address mux for as long as hold_req is high.
//
// Parameters
//   FIRST_REG  first register index dumped (0..31)
//   LAST_REG   last register index dumped (FIRST_REG..31)
//
// Compile-time option
//   REGDUMP_CHECKSUM_EN  when defined, a checksum beat (XOR of every
//                        register beat) follows the last register beat.
//
// Ports
//   clk        in   system clock, rising edge
//   reset      in   asynchronous active-high reset
//   start      in   one-cycle dump request, only sampled while idle
//   hold_req   out  pipeline freeze request / read-port mux select
//   hold_ack   in   pipeline frozen, no register write in flight
//   rd_addr1/2 out  register-file read addresses
//   rd_data1/2 in   register-file read data (combinational from rd_addr*)
//   out_valid  out  beat valid
//   out_ready  in   sink accepts beat
//   out_index  out  register index of the beat
//   out_data   out  register value or checksum
//   out_last   out  final beat of the dump
//   out_sum    out  beat carries the checksum
//   busy       out  engine not idle
//   done       out  one-cycle pulse when the dump completes
// ---------------------------------------------------------------------------
module regfile_dump_seq #(
  parameter int FIRST_REG = 1,
  parameter int LAST_REG  = 31
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic        hold_req,
  input  logic        hold_ack,
  output logic [4:0]  rd_addr1,
  output logic [4:0]  rd_addr2,
  input  logic [31:0] rd_data1,
  input  logic [31:0] rd_data2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  out_index,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        out_sum,
  output logic        busy,
  output logic        done
);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_REQ      = 3'd1;
  localparam logic [2:0] ST_READ     = 3'd2;
  localparam logic [2:0] ST_SEND_A   = 3'd3;
  localparam logic [2:0] ST_SEND_B   = 3'd4;
  localparam logic [2:0] ST_FIN      = 3'd6;
`ifdef REGDUMP_CHECKSUM_EN
  localparam logic [2:0] ST_SEND_SUM = 3'd5;
  // State entered after the last register beat has been accepted.
  localparam logic [2:0] ST_TAIL     = ST_SEND_SUM;
`else
  localparam logic [2:0] ST_TAIL     = ST_FIN;
`endif

  // Index arithmetic is one bit wider than a register index so that
  // idx+1 / idx+2 past 31 compare correctly against LAST_IDX.
  localparam logic [5:0] FIRST_IDX = 6'(FIRST_REG);
  localparam logic [5:0] LAST_IDX  = 6'(LAST_REG);

  logic [2:0]  state_q, state_d;
  logic [5:0]  idx_q, idx_d;
  logic [31:0] buf_a_q, buf_a_d;
  logic [31:0] buf_b_q, buf_b_d;
  logic [4:0]  rd_addr1_q, rd_addr1_d;
  logic [4:0]  rd_addr2_q, rd_addr2_d;

  logic [5:0]  idx_plus1;
  logic [5:0]  idx_plus2;

  assign idx_plus1 = idx_q + 6'd1;
  assign idx_plus2 = idx_q + 6'd2;

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    buf_a_d    = buf_a_q;
    buf_b_d    = buf_b_q;
    rd_addr1_d = rd_addr1_q;
    rd_addr2_d = rd_addr2_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          idx_d   = FIRST_IDX;
          state_d = ST_REQ;
        end
      end

      ST_REQ: begin
        // Addresses are registered on the way into READ so they are already
        // stable for the whole READ cycle.
        if (hold_ack) begin
          rd_addr1_d = idx_q[4:0];
          rd_addr2_d = idx_plus1[4:0];
          state_d    = ST_READ;
        end
      end

      ST_READ: begin
        // Losing the grant here means a write may be in flight; discard the
        // read and try the same pair again after the next grant.
        if (hold_ack) begin
          buf_a_d = rd_data1;
          buf_b_d = rd_data2;
          state_d = ST_SEND_A;
        end else begin
          state_d = ST_REQ;
        end
      end

      ST_SEND_A: begin
        if (out_ready) begin
          state_d = (idx_plus1 <= LAST_IDX) ? ST_SEND_B : ST_TAIL;
        end
      end

      ST_SEND_B: begin
        if (out_ready) begin
          if (idx_plus2 <= LAST_IDX) begin
            idx_d      = idx_plus2;
            rd_addr1_d = idx_plus2[4:0];
            rd_addr2_d = idx_plus2[4:0] + 5'd1;
            state_d    = ST_READ;
          end else begin
            state_d = ST_TAIL;
          end
        end
      end

`ifdef REGDUMP_CHECKSUM_EN
      ST_SEND_SUM: begin
        if (out_ready) begin
          state_d = ST_FIN;
        end
      end
`endif

      ST_FIN: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      idx_q      <= FIRST_IDX;
      buf_a_q    <= '0;
      buf_b_q    <= '0;
      rd_addr1_q <= '0;
      rd_addr2_q <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      buf_a_q    <= buf_a_d;
      buf_b_q    <= buf_b_d;
      rd_addr1_q <= rd_addr1_d;
      rd_addr2_q <= rd_addr2_d;
    end
  end

`ifdef REGDUMP_CHECKSUM_EN
  // -------------------------------------------------------------------------
  // Running XOR of every accepted register beat
  // -------------------------------------------------------------------------
  logic [31:0] sum_q, sum_d;
  logic        beat_acc;

  assign beat_acc = out_ready && ((state_q == ST_SEND_A) || (state_q == ST_SEND_B));

  always_comb begin
    sum_d = sum_q;
    if ((state_q == ST_IDLE) && start) begin
      sum_d = '0;
    end else if (beat_acc) begin
      sum_d = sum_q ^ out_data;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q <= '0;
    end else begin
      sum_q <= sum_d;
    end
  end
`endif

  // -------------------------------------------------------------------------
  // Outputs: decoded from registered state only, so they cannot change while
  // a beat is stalled (state and buffers hold when out_ready is low).
  // -------------------------------------------------------------------------
  always_comb begin
    out_valid = 1'b0;
    out_index = '0;
    out_data  = '0;
    out_last  = 1'b0;
    out_sum   = 1'b0;

    case (state_q)
      ST_SEND_A: begin
        out_valid = 1'b1;
        out_index = idx_q[4:0];
        out_data  = buf_a_q;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = (idx_plus1 > LAST_IDX);
`endif
      end

      ST_SEND_B: begin
        out_valid = 1'b1;
        out_index = idx_plus1[4:0];
        out_data  = buf_b_q;
`ifndef REGDUMP_CHECKSUM_EN
        out_last  = (idx_plus2 > LAST_IDX);
`endif
      end

`ifdef REGDUMP_CHECKSUM_EN
      ST_SEND_SUM: begin
        out_valid = 1'b1;
        out_index = '0;
        out_data  = sum_q;
        out_last  = 1'b1;
        out_sum   = 1'b1;
      end
`endif

      default: begin
      end
    endcase
  end

  assign busy     = (state_q != ST_IDLE);
  assign hold_req = (state_q != ST_IDLE);
  assign done     = (state_q == ST_FIN);
  assign rd_addr1 = rd_addr1_q;
  assign rd_addr2 = rd_addr2_q;

endmodule

// File: tb/tb_regfile_dump_seq.sv
`timescale 1ns/1ps
// Bench for regfile_dump_seq: three instances (1..31, 8..8, 1..11) share one
// register-file array. A per-instance model holds the expected beat list of
// the dump in progress; one compare step runs on every falling edge.
module tb_regfile_dump_seq;

  localparam int NI = 3;

`ifdef REGDUMP_CHECKSUM_EN
  localparam bit CS_EN = 1'b1;
`else
  localparam bit CS_EN = 1'b0;
`endif

  typedef struct packed {
    logic [4:0]  idx;
    logic [31:0] data;
    logic        last;
    logic        sum;
  } beat_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start_v     [NI];
  logic        hold_ack_v  [NI];
  logic        out_ready_v [NI];
  logic        hold_req_v  [NI];
  logic        out_valid_v [NI];
  logic        out_last_v  [NI];
  logic        out_sum_v   [NI];
  logic        busy_v      [NI];
  logic        done_v      [NI];
  logic [4:0]  rd_addr1_v  [NI];
  logic [4:0]  rd_addr2_v  [NI];
  logic [4:0]  out_index_v [NI];
  logic [31:0] rd_data1_v  [NI];
  logic [31:0] rd_data2_v  [NI];
  logic [31:0] out_data_v  [NI];
  logic [31:0] rf          [32];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int FR = (gi == 1) ? 8 : 1;
    localparam int LR = (gi == 0) ? 31 : ((gi == 1) ? 8 : 11);
    assign rd_data1_v[gi] = rf[rd_addr1_v[gi]];
    assign rd_data2_v[gi] = rf[rd_addr2_v[gi]];
    regfile_dump_seq #(.FIRST_REG(FR), .LAST_REG(LR)) u_dut (
      .clk       (clk),
      .reset     (rst),
      .start     (start_v[gi]),
      .hold_req  (hold_req_v[gi]),
      .hold_ack  (hold_ack_v[gi]),
      .rd_addr1  (rd_addr1_v[gi]),
      .rd_addr2  (rd_addr2_v[gi]),
      .rd_data1  (rd_data1_v[gi]),
      .rd_data2  (rd_data2_v[gi]),
      .out_valid (out_valid_v[gi]),
      .out_ready (out_ready_v[gi]),
      .out_index (out_index_v[gi]),
      .out_data  (out_data_v[gi]),
      .out_last  (out_last_v[gi]),
      .out_sum   (out_sum_v[gi]),
      .busy      (busy_v[gi]),
      .done      (done_v[gi])
    );
  end

  function automatic int first_of(input int i);
    return (i == 1) ? 8 : 1;
  endfunction

  function automatic int last_of(input int i);
    return (i == 0) ? 31 : ((i == 1) ? 8 : 11);
  endfunction

  // ---------------- model state ----------------
  int    errors = 0;
  int    checks = 0;
  int    cyc    = 0;
  int    phase   [NI];   // 0 idle, 1 beats outstanding, 2 done expected now
  int    exp_n   [NI];
  int    exp_p   [NI];
  int    obs_n   [NI];
  int    t_start [NI];
  int    t_first [NI];
  int    t_done  [NI];
  bit    stalled    [NI];
  bit    prev_valid [NI];
  bit    ack_h1     [NI];
  beat_t saved_b [NI];
  beat_t exp_b   [NI][40];
  beat_t obs_b   [NI][40];
  logic [NI-1:0] st_r, rdy_r, ack_r;

  task automatic chk(input string name, input int i, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s inst%0d cycle %0d: got %0h expected %0h", name, i, cyc, act, expv);
    end
  endtask

  function automatic beat_t cur_beat(input int i);
    beat_t b;
    b.idx  = out_index_v[i];
    b.data = out_data_v[i];
    b.last = out_last_v[i];
    b.sum  = out_sum_v[i];
    return b;
  endfunction

  // Expected beats straight from the register range and the current file.
  task automatic load_expected(input int i);
    logic [31:0] x;
    int n;
    x = '0;
    n = 0;
    for (int r = first_of(i); r <= last_of(i); r++) begin
      exp_b[i][n].idx  = 5'(r);
      exp_b[i][n].data = rf[r];
      exp_b[i][n].last = !CS_EN && (r == last_of(i));
      exp_b[i][n].sum  = 1'b0;
      x = x ^ rf[r];
      n++;
    end
    if (CS_EN) begin
      exp_b[i][n].idx  = 5'd0;
      exp_b[i][n].data = x;
      exp_b[i][n].last = 1'b1;
      exp_b[i][n].sum  = 1'b1;
      n++;
    end
    exp_n[i] = n;
    exp_p[i] = 0;
  endtask

  // Called with the inputs that will be sampled at the coming rising edge.
  task automatic update_inst(input int i, input logic st, input logic rdy, input logic ack);
    stalled[i]    = out_valid_v[i] && !rdy;
    saved_b[i]    = cur_beat(i);
    prev_valid[i] = out_valid_v[i];
    ack_h1[i]     = ack;
    if (out_valid_v[i] && rdy && obs_n[i] < 40) begin
      obs_b[i][obs_n[i]] = cur_beat(i);
      obs_n[i]++;
    end
    if (phase[i] == 2) begin
      phase[i] = 0;
    end else if (phase[i] == 0) begin
      if (st) begin
        load_expected(i);
        phase[i]   = 1;
        obs_n[i]   = 0;
        t_start[i] = cyc;
        t_first[i] = -1;
        t_done[i]  = -1;
      end
    end else if (out_valid_v[i] && rdy && exp_p[i] < exp_n[i]) begin
      exp_p[i]++;
      if (exp_p[i] == exp_n[i]) phase[i] = 2;
    end
  endtask

  task automatic check_inst(input int i);
    chk("done", i, done_v[i], phase[i] == 2);
    chk("busy", i, busy_v[i], phase[i] != 0);
    chk("hold_req", i, hold_req_v[i], phase[i] != 0);
    if (phase[i] == 1 && exp_p[i] < exp_n[i]) begin
      if (out_valid_v[i]) begin
        chk("beat", i, cur_beat(i), exp_b[i][exp_p[i]]);
      end
    end else begin
      chk("out_valid", i, out_valid_v[i], 1'b0);
    end
    // A new beat can only follow a READ cycle during which the grant held.
    if (out_valid_v[i] && !prev_valid[i]) begin
      chk("rise_needs_ack", i, ack_h1[i], 1'b1);
      if (t_first[i] < 0) t_first[i] = cyc;
    end
    if (stalled[i]) begin
      chk("stall_valid", i, out_valid_v[i], 1'b1);
      chk("stall_beat", i, cur_beat(i), saved_b[i]);
    end
    if (done_v[i]) begin
      t_done[i] = cyc;
      $display("dump inst%0d complete at cycle %0d with %0d beats", i, cyc, obs_n[i]);
    end
  endtask

  task automatic cycle(input logic [NI-1:0] st, input logic [NI-1:0] rdy, input logic [NI-1:0] ack);
    for (int i = 0; i < NI; i++) begin
      start_v[i]     = st[i];
      out_ready_v[i] = rdy[i];
      hold_ack_v[i]  = ack[i];
      update_inst(i, st[i], rdy[i], ack[i]);
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) check_inst(i);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    for (int i = 0; i < NI; i++) begin
      chk("rst_hold_req_now", i, hold_req_v[i], 1'b0);
      chk("rst_valid_now", i, out_valid_v[i], 1'b0);
      chk("rst_done_now", i, done_v[i], 1'b0);
      phase[i] = 0; exp_n[i] = 0; exp_p[i] = 0;
      stalled[i] = 1'b0; prev_valid[i] = 1'b0; ack_h1[i] = 1'b0;
      start_v[i] = 1'b0;
    end
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NI; i++) begin
      check_inst(i);
      chk("rst_rd_addr1", i, rd_addr1_v[i], 5'd0);
      chk("rst_rd_addr2", i, rd_addr2_v[i], 5'd0);
      chk("rst_out_index", i, out_index_v[i], 5'd0);
      chk("rst_out_data", i, out_data_v[i], 32'd0);
      chk("rst_out_last_sum", i, {out_last_v[i], out_sum_v[i]}, 2'b00);
    end
    rst = 1'b0;
  endtask

  // Run without new starts until every instance is idle or the budget ends.
  task automatic wait_idle(input int budget, input bit rnd);
    int n;
    n = 0;
    while ((phase[0] != 0 || phase[1] != 0 || phase[2] != 0) && n < budget) begin
      if (rnd) begin
        rdy_r = 3'($urandom);
        ack_r = ~(3'($urandom) & 3'($urandom));
      end else begin
        rdy_r = '1;
        ack_r = '1;
      end
      cycle('0, rdy_r, ack_r);
      n++;
    end
    if (n >= budget) begin
      for (int i = 0; i < NI; i++) chk("timeout_phase", i, phase[i], 0);
      do_reset();
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c3, c4;
    int n;
    for (int r = 0; r < 32; r++) rf[r] = '0;
    rf[1] = 10; rf[2] = 20; rf[3] = 30; rf[4] = 40;
    rf[8] = 200; rf[9] = 100; rf[10] = 50; rf[11] = 60;
    for (int i = 0; i < NI; i++) begin
      start_v[i] = 1'b0; hold_ack_v[i] = 1'b0; out_ready_v[i] = 1'b0;
      obs_n[i] = 0; t_start[i] = 0; t_first[i] = -1; t_done[i] = -1;
    end
    rst = 1'b1;
    do_reset();

    // ---- directed: ack/ready tied high, all three dumps at once ----
    cycle('1, '1, '1);
    wait_idle(200, 1'b0);
    chk("lat_first_valid", 0, t_first[0] - t_start[0], 3);
    chk("lat_first_valid", 1, t_first[1] - t_start[1], 3);
    chk("lat_first_valid", 2, t_first[2] - t_start[2], 3);
    chk("lat_done", 0, t_done[0] - t_start[0], 49);
    chk("lat_done", 1, t_done[1] - t_start[1], 4);
    chk("lat_done", 2, t_done[2] - t_start[2], CS_EN ? 20 : 19);
    chk("beats_full", 0, obs_n[0], 31);
    chk("beat8_full", 0, {obs_b[0][7].idx, obs_b[0][7].data}, {5'd8, 32'd200});
    chk("beats_single", 1, obs_n[1], 1);
    chk("beat_single", 1, obs_b[1][0], {5'd8, 32'd200, 1'b1, 1'b0});
`ifdef REGDUMP_CHECKSUM_EN
    chk("beats_r11", 2, obs_n[2], 12);
    chk("checksum_beat", 2, obs_b[2][11], {5'd0, 32'h0000008A, 1'b1, 1'b1});
`else
    chk("beats_r11", 2, obs_n[2], 11);
    chk("last_beat_r11", 2, obs_b[2][10], {5'd11, 32'd60, 1'b1, 1'b0});
`endif

    // ---- directed: grant withheld, then lost during READ of {3,4} ----
    cycle(3'b001, '1, 3'b000);
    repeat (4) cycle('0, '1, 3'b000);
    chk("no_beat_without_grant", 0, out_valid_v[0], 1'b0);
    n = 0;
    while (!(out_valid_v[0] && out_index_v[0] == 5'd2) && n < 50) begin
      cycle('0, '1, '1);
      n++;
    end
    chk("reach_beat2", 0, n < 50, 1'b1);
    cycle('0, '1, '1);        // beat 2 accepted, enter READ {3,4}
    cycle('0, '1, 3'b110);    // grant lost during that READ
    chk("no_beat_after_drop", 0, out_valid_v[0], 1'b0);
    wait_idle(200, 1'b0);
    c3 = 0; c4 = 0;
    for (int k = 0; k < obs_n[0]; k++) begin
      if (obs_b[0][k].idx == 5'd3 && obs_b[0][k].data == 32'd30) c3++;
      if (obs_b[0][k].idx == 5'd4 && obs_b[0][k].data == 32'd40) c4++;
    end
    chk("reg3_once", 0, c3, 1);
    chk("reg4_once", 0, c4, 1);

    // ---- directed: reset while instance 0 sits in SEND_B ----
    cycle('1, 3'b110, '1);
    n = 0;
    while (!(out_valid_v[0] && out_index_v[0] == 5'd4) && n < 50) begin
      cycle('0, 3'b110 | 3'(out_index_v[0] < 5'd4), '1);
      n++;
    end
    chk("reach_send_b", 0, n < 50, 1'b1);
    do_reset();
    cycle(3'b001, '1, '1);
    wait_idle(200, 1'b0);
    chk("fresh_dump_beats", 0, obs_n[0], 31);
    chk("fresh_dump_first", 0, {obs_b[0][0].idx, obs_b[0][0].data}, {5'd1, 32'd10});

    // ---- randomized: random file contents, starts, stalls and grants ----
    for (int r = 0; r < 5; r++) begin
      for (int k = 1; k < 32; k++) rf[k] = $urandom;
      for (int c = 0; c < 300; c++) begin
        st_r  = 3'($urandom) & 3'($urandom);
        rdy_r = 3'($urandom);
        ack_r = ~(3'($urandom) & 3'($urandom));
        cycle(st_r, rdy_r, ack_r);
      end
      wait_idle(800, 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/regfile_dump_seq.md
# regfile_dump_seq

Sequential read-out engine for the MIPS register file: on a start pulse it freezes the pipeline, steps the register file's two asynchronous read ports over a configurable register range two registers at a time, and streams each register value out over a valid/ready interface. It sits beside the decode stage and owns the read-port address mux while its freeze request is granted. It is used for end-of-program result dumps to the testbench or to a debug UART.

## Interface
- FIRST_REG, 1, first register index dumped (0..31).
- LAST_REG, 31, last register index dumped (FIRST_REG..31).
- clk  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- hold_req  out  1  pipeline freeze request; also selects this block's addresses onto the register-file read ports.
- hold_ack  in  1  pipeline frozen, with no register write in flight.
- rd_addr1, rd_addr2  out  5  register-file read addresses.
- rd_data1, rd_data2  in  32  register-file read data (combinational from rd_addr*).
- out_valid  out  1  beat valid.
- out_ready  in  1  sink accepts beat.
- out_index  out  5  register index of beat.
- out_data  out  32  register value or checksum.
- out_last  out  1  final beat of dump.
- out_sum  out  1  beat carries checksum (constant 0 when checksum is compiled out).
- busy  out  1  state != IDLE.
- done  out  1  one-cycle pulse when the dump completes.

## Operation
- States: IDLE, REQ, READ, SEND_A, SEND_B, SEND_SUM, FIN.
- IDLE: `start` = 1 loads `idx` = FIRST_REG, clears checksum -> REQ.
- REQ: `hold_req` = 1. `hold_ack` = 1 -> READ.
- READ: `rd_addr1` = idx, `rd_addr2` = idx+1 (registered, stable during READ). At the end of the cycle, `rd_data1`/`rd_data2` are captured into bufA/bufB -> SEND_A.
  - If `hold_ack` = 0 during READ, nothing is captured -> REQ. The same pair is re-read after the next grant.
- SEND_A: `out_valid` = 1, `out_index` = idx, `out_data` = bufA. On `out_ready`:
  - if idx+1 <= LAST_REG -> SEND_B;
  - else -> SEND_SUM (macro on) or FIN.
- SEND_B: `out_index` = idx+1, `out_data` = bufB. On `out_ready`:
  - if idx+2 <= LAST_REG: idx += 2 -> READ;
  - else -> SEND_SUM or FIN.
- Checksum: 32-bit XOR of every accepted register beat.
- FIN: `done` = 1 for one cycle, `hold_req` drops -> IDLE.
- `out_last` = 1 on the last register beat (macro off) or on the SEND_SUM beat (macro on).
- Index arithmetic is 6-bit internally, so idx+2 past 31 cannot wrap.
- A `start` pulse while busy is ignored.
- Outputs are held stable while `out_valid` = 1 and `out_ready` = 0.
- A `hold_ack` drop during SEND_A/SEND_B has no effect: data is already buffered.

## Timing
- Reset values: all outputs 0, state IDLE, `idx` = FIRST_REG, buffers and checksum 0.
- Latency with `hold_ack` and `out_ready` tied high:
  - `start` edge T0 -> REQ; T1 -> READ; first `out_valid` at T2.
  - Throughput: 2 beats per 3 cycles.
- `hold_req` asserts the cycle after `start` is sampled. It stays high from REQ through FIN inclusive and deasserts the cycle after `done`.
- Reset mid-dump: `hold_req` and `out_valid` go low asynchronously; no `done` pulse; the next `start` begins a fresh dump.

## Configuration
- REGDUMP_CHECKSUM_EN defined:
  - SEND_SUM is appended after the last register beat: `out_sum` = 1, `out_index` = 0, `out_data` = XOR checksum, `out_last` = 1.
- Undefined:
  - no SEND_SUM state or checksum register;
  - `out_sum` tied 0;
  - `out_last` on the last register beat.

## Test plan
- Default params, regfile preloaded ($1=10, $2=20, $3=30, $4=40, $8=200, $9=100, $10=50, $11=60), ready/ack high, `start` -> 31 beats with indices 1..31 and matching data; `done` asserted exactly once; first `out_valid` 2 cycles after the `start` edge.
- FIRST_REG=1, LAST_REG=11, macro on -> 11 register beats, then a checksum beat with `out_data` = 0x0000008A, `out_sum` = 1, `out_last` = 1.
- FIRST_REG=LAST_REG=8 (odd range) -> single beat (index 8, data 200) with `out_last` = 1 (macro off); SEND_B is never entered.
- `hold_ack` held low 5 cycles, then dropped during READ of pair {3,4} -> no beat until re-grant; afterwards $3=30 and $4=40 are emitted once each.
- `out_ready` toggles 0/1 randomly -> `out_data`/`out_index` are stable while stalled; beat sequence is identical to the no-stall case.
- `reset` pulsed while in SEND_B -> `hold_req`/`out_valid` low immediately, no `done`; a new `start` dumps from FIRST_REG correctly.
